vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

- Generates 640x480@60 Hz VGA raster timing: `hCount`, `vCount`, `bright`, `hSync` and `vSync`.
- Takes the 12-bit pixel colour back from the object/scene controller and drives it to the DAC pins.
- Sits between the board clock and the scene controller: the scene controller consumes `hCount`/`vCount`/`bright` and returns `rgb`.
- Also emits a once-per-frame tick that game-state logic uses as its update strobe.

## Interface
Parameters:
- CLK_DIV, 4, board clocks per pixel (100 MHz -> 25 MHz); legal range 2..16
- H_TOTAL, 800, pixels per line (hCount 0..H_TOTAL-1)
- H_SYNC, 96, hSync low for hCount < H_SYNC
- H_ACT_START, 144, first visible column
- H_ACT_END, 784, first non-visible column after active region
- V_TOTAL, 525, lines per frame (vCount 0..V_TOTAL-1)
- V_SYNC, 2, vSync low for vCount < V_SYNC
- V_ACT_START, 35, first visible line
- V_ACT_END, 515, first non-visible line after active region

Ports:
- clk, in, 1, board clock. Reset is `rst`, asynchronous, active-high; clock is `clk`.
- rst, in, 1, asynchronous active-high reset
- rgb_in, in, 12, colour for the current (hCount, vCount), from the scene controller
- pix_en, out, 1, one-clk pulse marking the last clk of each pixel period
- hCount, out, 10, current column
- vCount, out, 10, current line
- bright, out, 1, high when the current pixel is inside the visible window
- hSync, out, 1, active-low horizontal sync to the connector
- vSync, out, 1, active-low vertical sync to the connector
- rgb_out, out, 12, colour to the DAC pins; 0 outside the visible window
- frame_tick, out, 1, one-clk pulse at the start of each frame

## Operation
- **Divider.** div_cnt counts 0..CLK_DIV-1 and wraps to 0. `pix_en` is the combinational decode `div_cnt == CLK_DIV-1`.
- **Counters.** On a clk edge with `pix_en` = 1:
  - `hCount` increments.
  - At H_TOTAL-1 it wraps to 0 and `vCount` increments.
  - `vCount` wraps from V_TOTAL-1 to 0 when `hCount` also wraps.
  - Counters hold on all other edges.
- **Decodes.** `hSync`, `vSync` and `bright` are registered, computed from the next counter values, so they are always consistent with `hCount`/`vCount` in the same cycle.
  - hSync = !(hCount < H_SYNC)
  - vSync = !(vCount < V_SYNC)
  - bright = (H_ACT_START <= hCount < H_ACT_END) && (V_ACT_START <= vCount < V_ACT_END)
- **Frame tick.** `frame_tick` is registered and high for exactly one clk: the first clk cycle in which the counters read (0,0) after wrapping from (H_TOTAL-1, V_TOTAL-1). It is not asserted after reset release.
- **Blanking.** `rgb_out` is forced to 0 whenever the pixel it belongs to has `bright` = 0, regardless of `rgb_in`.
- **Comparisons.** All comparisons are unsigned, 10-bit. Parameters must satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024.
- **Reset.** Reset mid-frame returns everything to reset values immediately. No partial line or frame is completed.

## Timing
- **Reset values:** div_cnt=0, pix_en=0, hCount=0, vCount=0, hSync=0, vSync=0, bright=0, rgb_out=0, frame_tick=0.
- **First advance:** after `rst` falls, the first `pix_en` is high during clk cycle CLK_DIV-1. `hCount` becomes 1 on that edge.
- **Line and frame length:** one line = H_TOTAL*CLK_DIV clks (3200); one frame = V_TOTAL lines (1,680,000 clks).
- **Transition edges:** `hSync` rises on the pix_en edge where `hCount` becomes H_SYNC, and falls where it becomes 0.
- **Tick spacing:** the frame_tick period is exactly H_TOTAL*V_TOTAL*CLK_DIV clks.
- **Colour latency without RGB_PIPE_EN:** `rgb_out` is combinational from `rgb_in` and `bright`, with zero latency.
- **Colour latency with RGB_PIPE_EN:** `rgb_out` lags `rgb_in` by one pixel. `hSync`/`vSync` are delayed by the same one-pixel stage so the connector stays aligned.

## Configuration
- **Macro:** RGB_PIPE_EN.
- **Defined:**
  - `rgb_out` is a register loaded on pix_en edges with (bright ? rgb_in : 0).
  - The `hSync`/`vSync` port outputs pass through one matching pix_en-enabled register stage; reset value 0 for both.
  - `hCount`/`vCount`/`bright`/`frame_tick` are unaffected.
  - Use this when the scene controller's combinational path does not close timing.
- **Undefined:** `rgb_out` = bright ? rgb_in : 0 combinationally; `hSync`/`vSync` are driven straight from the decode registers.

## Test plan
- **Reset and divider:** hold rst, release it, CLK_DIV=4 -> `pix_en` is high on clks 3, 7, 11; `hCount` reads 1, 2, 3 after them; `vCount`=0.
- **Line wrap:** run to hCount=799 -> the next pix_en edge gives hCount=0 and vCount=1; `hSync` is 0 for hCount 0..95 and 1 for 96..799.
- **Window corners:** check `bright` at (143,35)=0, (144,35)=1, (783,514)=1, (784,514)=0, (144,515)=0; `rgb_in`=12'hF00 throughout -> `rgb_out`=F00 only where `bright`=1, else 0.
- **Frame wrap:** run to (799,524) -> one pix_en later counters read (0,0) and `frame_tick` is high for exactly 1 clk; the next tick comes 1,680,000 clks later; `vSync` is 0 only for vCount 0..1.
- **Reset mid-frame:** assert rst at (400,200) -> all outputs return to reset values asynchronously; after release, timing restarts from (0,0) with no `frame_tick`.
- **RGB_PIPE_EN defined:** step `rgb_in` from 0 to 12'h0F0 at hCount=300, vCount=100 -> `rgb_out` changes at the pix_en edge where hCount becomes 301; the `hSync` port falls one pixel after hCount becomes 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA raster timing generator with colour blanking and a per-frame tick.
// Define RGB_PIPE_EN to register rgb_out and the sync outputs by one pixel.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_ACT_START = 144,
    parameter int unsigned H_ACT_END   = 784,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_ACT_START = 35,
    parameter int unsigned V_ACT_END   = 515
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
    output logic        pix_en,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic        hSync,
    output logic        vSync,
    output logic [11:0] rgb_out,
    output logic        frame_tick
);

    localparam int unsigned DivW = $clog2(CLK_DIV);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]      h_cnt_q, h_cnt_d;
    logic [9:0]      v_cnt_q, v_cnt_d;
    logic            h_last, v_last;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            bright_q, bright_d;
    logic            frame_tick_q, frame_tick_d;

    assign pix_en = (div_cnt_q == DivW'(CLK_DIV - 1));
    assign h_last = (h_cnt_q == 10'(H_TOTAL - 1));
    assign v_last = (v_cnt_q == 10'(V_TOTAL - 1));

    always_comb begin
        div_cnt_d = pix_en ? '0 : div_cnt_q + DivW'(1);
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (pix_en) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Decodes use the next counter values so the registered outputs line up with hCount/vCount.
    always_comb begin
        hsync_d      = !(h_cnt_d < 10'(H_SYNC));
        vsync_d      = !(v_cnt_d < 10'(V_SYNC));
        bright_d     = (h_cnt_d >= 10'(H_ACT_START)) && (h_cnt_d < 10'(H_ACT_END)) &&
                       (v_cnt_d >= 10'(V_ACT_START)) && (v_cnt_d < 10'(V_ACT_END));
        frame_tick_d = pix_en && h_last && v_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q    <= '0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            bright_q     <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            bright_q     <= bright_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign hCount     = h_cnt_q;
    assign vCount     = v_cnt_q;
    assign bright     = bright_q;
    assign frame_tick = frame_tick_q;

`ifdef RGB_PIPE_EN
    logic [11:0] rgb_q;
    logic        hsync_pipe_q, vsync_pipe_q;

    // Sync outputs ride the same one-pixel stage as the colour to keep the connector aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q        <= '0;
            hsync_pipe_q <= 1'b0;
            vsync_pipe_q <= 1'b0;
        end else if (pix_en) begin
            rgb_q        <= bright_q ? rgb_in : '0;
            hsync_pipe_q <= hsync_q;
            vsync_pipe_q <= vsync_q;
        end
    end

    assign rgb_out = rgb_q;
    assign hSync   = hsync_pipe_q;
    assign vSync   = vsync_pipe_q;
`else
    assign rgb_out = bright_q ? rgb_in : '0;
    assign hSync   = hsync_q;
    assign vSync   = vsync_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster (20x10 pixels, 4 clks/pixel).
module tb_vga_timing_gen;

    localparam int unsigned CDIV = 4;
    localparam int unsigned HT   = 20;
    localparam int unsigned HS   = 3;
    localparam int unsigned HA0  = 5;
    localparam int unsigned HA1  = 17;
    localparam int unsigned VT   = 10;
    localparam int unsigned VS   = 2;
    localparam int unsigned VA0  = 3;
    localparam int unsigned VA1  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] rgb_in;
    logic        pix_en;
    logic [9:0]  hCount, vCount;
    logic        bright, hSync, vSync, frame_tick;
    logic [11:0] rgb_out;

    int n_chk  = 0;
    int n_pass = 0;

    vga_timing_gen #(
        .CLK_DIV    (CDIV),
        .H_TOTAL    (HT),
        .H_SYNC     (HS),
        .H_ACT_START(HA0),
        .H_ACT_END  (HA1),
        .V_TOTAL    (VT),
        .V_SYNC     (VS),
        .V_ACT_START(VA0),
        .V_ACT_END  (VA1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rgb_in    (rgb_in),
        .pix_en    (pix_en),
        .hCount    (hCount),
        .vCount    (vCount),
        .bright    (bright),
        .hSync     (hSync),
        .vSync     (vSync),
        .rgb_out   (rgb_out),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance on negedges to the pix_en cycle of pixel (h, v).
    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(pix_en && hCount == 10'(h) && vCount == 10'(v)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check_eq("run_to_timeout", 32'(n), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_pix_en"}, pix_en, 0);
        check_eq({tag, "_hcount"}, hCount, 0);
        check_eq({tag, "_vcount"}, vCount, 0);
        check_eq({tag, "_hsync"}, hSync, 0);
        check_eq({tag, "_vsync"}, vSync, 0);
        check_eq({tag, "_bright"}, bright, 0);
        check_eq({tag, "_rgb_out"}, rgb_out, 0);
        check_eq({tag, "_frame_tick"}, frame_tick, 0);
    endtask

    initial begin
        int ticks;
        logic exp_hs;

        rst    = 1'b1;
        rgb_in = 12'hF00;
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        // Divider: pix_en in cycles 3, 7, 11; hCount steps once per 4 clks.
        rst = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            check_eq("div_pix_en", pix_en, 32'(cyc % 4 == 3));
            check_eq("div_hcount", hCount, 32'(cyc / 4));
            @(negedge clk);
        end
        check_eq("div_hcount_3", hCount, 3);
        check_eq("div_vcount", vCount, 0);

        // Line wrap then hSync sweep over line 1.
        run_to(19, 0);
        check_eq("wrap_pre_hsync", hSync, 1);
        @(negedge clk);
        check_eq("wrap_vcount", vCount, 1);
        for (int k = 0; k < 20; k++) begin
`ifdef RGB_PIPE_EN
            exp_hs = (k == 0) ? 1'b1 : (k - 1 >= 3);
`else
            exp_hs = (k >= 3);
`endif
            check_eq("line_hcount", hCount, 32'(k));
            check_eq("line_hsync", hSync, 32'(exp_hs));
            repeat (4) @(negedge clk);
        end

        // Window corners with rgb_in = F00.
        run_to(4, 3);
        check_eq("corner_4_3_bright", bright, 0);
        run_to(5, 3);
        check_eq("corner_5_3_bright", bright, 1);
`ifndef RGB_PIPE_EN
        check_eq("corner_5_3_rgb", rgb_out, 12'hF00);
        rgb_in = 12'h0AB;
        #1;
        check_eq("corner_5_3_rgb_alt", rgb_out, 12'h0AB);
        rgb_in = 12'hF00;
`endif
        run_to(16, 7);
        check_eq("corner_16_7_bright", bright, 1);
`ifndef RGB_PIPE_EN
        check_eq("corner_16_7_rgb", rgb_out, 12'hF00);
`endif
        run_to(17, 7);
        check_eq("corner_17_7_bright", bright, 0);
        check_eq("corner_17_7_rgb", rgb_out, 0);
        run_to(5, 8);
        check_eq("corner_5_8_bright", bright, 0);
        check_eq("corner_5_8_rgb", rgb_out, 0);

        // Frame wrap, tick width and spacing (HT*VT*CDIV = 800 clks), vSync per line.
        run_to(19, 9);
        check_eq("fw_pre_tick", frame_tick, 0);
        check_eq("fw_pre_vsync", vSync, 1);
        @(negedge clk);
        check_eq("fw_hcount", hCount, 0);
        check_eq("fw_vcount", vCount, 0);
        check_eq("fw_tick", frame_tick, 1);
`ifndef RGB_PIPE_EN
        check_eq("fw_vsync", vSync, 0);
`endif
        ticks = 0;
        for (int n = 1; n <= 800; n++) begin
            @(negedge clk);
            if (n == 1) check_eq("fw_tick_width", frame_tick, 0);
            if (n % 80 == 4) begin
                check_eq("fw_line_vcount", vCount, 32'(n / 80));
                check_eq("fw_line_vsync", vSync, 32'(n / 80 >= 2));
            end
            if (n < 800 && frame_tick) ticks++;
        end
        check_eq("fw_tick_period", frame_tick, 1);
        check_eq("fw_no_spurious_tick", 32'(ticks), 0);

        // Asynchronous reset mid-frame, then restart from (0,0) without a tick.
        run_to(10, 5);
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        rst = 1'b0;
        ticks = 0;
        repeat (84) begin
            if (frame_tick) ticks++;
            @(negedge clk);
        end
        check_eq("midrst_hcount", hCount, 1);
        check_eq("midrst_vcount", vCount, 1);
        check_eq("midrst_no_tick", 32'(ticks), 0);

        // Colour step at pixel (10,4) and sync alignment at the next line start.
        rgb_in = 12'h000;
        run_to(9, 4);
        @(negedge clk);
        rgb_in = 12'h0F0;
`ifdef RGB_PIPE_EN
        run_to(10, 4);
        check_eq("pipe_rgb_hold", rgb_out, 0);
        @(negedge clk);
        check_eq("pipe_rgb_hcount", hCount, 11);
        check_eq("pipe_rgb_step", rgb_out, 12'h0F0);
        run_to(19, 4);
        @(negedge clk);
        check_eq("pipe_hsync_line_start", hSync, 1);
        repeat (4) @(negedge clk);
        check_eq("pipe_hsync_fall", hSync, 0);
`else
        #1;
        check_eq("comb_rgb_step", rgb_out, 12'h0F0);
        run_to(19, 4);
        @(negedge clk);
        check_eq("comb_hsync_line_start", hSync, 0);
        check_eq("comb_line_rgb_blank", rgb_out, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
